board_sched: RTL and testbench
==============================

BOARD_SCHED -- requirements
Module: board_sched

Interface
REQ-001 SHALL have parameter N_CELLS, default 81, number of board cells (9x9, row-major).
REQ-002 SHALL have parameter LAST_IDX, default 8, highest row/column index.
REQ-003 SHALL have port Clk, input, 1, sole clock; all logic is rising-edge.
REQ-004 SHALL have port Reset, input, 1, synchronous, active-low reset.
REQ-005 SHALL have ports R, L, U, D, C, CheckSolu, Ack, input, 1 each, one-cycle user command pulses.
REQ-006 SHALL have port userIn, input, 5, digit written on C.
REQ-007 SHALL have port mem_addr, output, 7, shared board port address (row*9+col).
REQ-008 SHALL have ports mem_we (output, 1) and mem_wdata (output, 5), board write strobe and data.
REQ-009 SHALL have ports mem_rdata and solu_rdata, input, 5 each, puzzle and solution data for the address issued one cycle earlier.
REQ-010 SHALL have ports disp_req (input, 1) and disp_addr (input, 7), display read request and address.
REQ-011 SHALL have ports disp_gnt, disp_valid (output, 1 each) and disp_data (output, 5), display grant, read-return strobe and data.
REQ-012 SHALL have ports row, col, output, 4 each, cursor position.
REQ-013 SHALL have ports q_I, q_Solve, q_Check, q_Correct, q_Incorrect, output, 1 each, one-hot state.
REQ-014 SHALL have ports init (output, 1), one-cycle board-reload pulse, and err_count (output, 7), mismatches found by the last check.

Function
REQ-015 States: I, SOLVE, CHECK, CORRECT, INCORRECT; exactly one q_* high.
REQ-016 I SHALL assert init for one cycle, set row=col=0, and go to SOLVE the next cycle.
REQ-017 SOLVE priority SHALL be CheckSolu > R > L > U > D > C; lower-priority pulses in the same cycle are dropped.
REQ-018 R/L/D/U SHALL move col+1/col-1/row+1/row-1 with no wrap: ignored at LAST_IDX/0 edge.
REQ-019 C SHALL queue a write of userIn to (row,col) only if userIn <= 9; otherwise it is ignored.
REQ-020 A one-entry pending buffer SHALL hold a queued write until granted; a C arriving while it is full is dropped.
REQ-021 CheckSolu SHALL clear err_count, set the check index to 0 and enter CHECK; a pending write is completed first.
REQ-022 Port arbitration SHALL, each cycle, grant one requester: internal (pending write or check read) or display.
REQ-023 When both request, the requester not granted last SHALL win (round-robin); a lone requester always wins.
REQ-024 disp_gnt SHALL be combinational in the grant cycle; disp_valid and disp_data=mem_rdata follow exactly one cycle later.
REQ-025 mem_we SHALL be high only in a cycle where the pending write is granted.
REQ-026 CHECK SHALL issue reads 0..80 on internal grants; one cycle after each, it SHALL compare mem_rdata to solu_rdata and saturate-increment err_count (max 81) on mismatch.
REQ-027 After comparing index 80, next state SHALL be CORRECT if err_count==0, else INCORRECT.
REQ-028 Command pulses other than Ack SHALL be ignored in CHECK, CORRECT and INCORRECT.
REQ-029 Ack in CORRECT or INCORRECT SHALL go to I; err_count holds until the next CheckSolu.

Reset
REQ-030 Reset low at a clock edge SHALL set state=I, row=col=0, pending empty, rr pointer to display, err_count=0, and all strobes (mem_we, disp_gnt, disp_valid, init) low.
REQ-031 Reset mid-CHECK or with a pending write SHALL abandon the operation with no further mem_we.

Structure
REQ-032 State encodings, N_CELLS, LAST_IDX and the address width SHALL live in a shared package, sindoku_pkg.
REQ-033 The two-requester round-robin SHALL be a sub-module, rr_arb2.

Verification
REQ-034 Reset, then idle: init pulses once, then q_Solve=1, row=col=0.
REQ-035 At row=col=0, pulse L then U: row and col stay 0; at col=8, pulse R: col stays 8.
REQ-036 Hold disp_req=1, pulse C with userIn=7 at (1,2): mem_we=1 with mem_addr=11 and wdata=7 within 2 cycles; grants alternate display/internal.
REQ-037 C with userIn=12: no mem_we ever.
REQ-038 CheckSolu with a model where only cell 40 mismatches and disp_req=0: 81 reads, err_count=1, q_Incorrect=1; Ack -> q_I then q_Solve.
REQ-039 Same with no mismatches and disp_req held high: CHECK takes about 162 cycles, q_Correct=1; Reset low mid-check -> q_I, no further reads.

Source files
------------

// File: rtl/sindoku_pkg.sv
// sindoku_pkg: shared definitions for the board scheduler.
//   - controller state encoding (state_t)
//   - default board geometry (N_CELLS_DEF, LAST_IDX_DEF)
//   - board port address/data widths and cursor width
//   - cell_addr(): row-major cell index from a cursor position
package sindoku_pkg;

  localparam int N_CELLS_DEF  = 81;  // 9x9 board, row-major
  localparam int LAST_IDX_DEF = 8;   // highest row/column index
  localparam int ADDR_W       = 7;   // board port address width
  localparam int DATA_W       = 5;   // cell digit width
  localparam int POS_W        = 4;   // cursor row/col width

  typedef enum logic [2:0] {
    S_I         = 3'd0,
    S_SOLVE     = 3'd1,
    S_CHECK     = 3'd2,
    S_CORRECT   = 3'd3,
    S_INCORRECT = 3'd4
  } state_t;

  // Row-major address of (r, c) on a board that is 'cols' cells wide.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [POS_W-1:0] r,
                                                  input logic [POS_W-1:0] c,
                                                  input int               cols);
    return ADDR_W'(r) * ADDR_W'(cols) + ADDR_W'(c);
  endfunction

endpackage

// File: rtl/board_sched_if.sv
// board_sched_if: the shared board memory port plus the display read port.
//
// Handshake rules (one place for all of them):
//   - mem_addr/mem_we/mem_wdata are driven by the scheduler every cycle; a
//     write happens when mem_we is high. mem_rdata/solu_rdata return the data
//     for the address driven in the previous cycle.
//   - disp_req is a level request with disp_addr; there is no backpressure on
//     the return path. disp_gnt is high in the cycle disp_addr is placed on
//     mem_addr; disp_valid/disp_data follow exactly one cycle later.
//
// Modports:
//   master : the scheduler (drives the memory port, answers the display)
//   slave  : memory + display side (bench or board RAM wrapper)
interface board_sched_if;
  import sindoku_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] solu_rdata;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;

  modport master (
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata, solu_rdata,
    input  disp_req, disp_addr,
    output disp_gnt, disp_valid, disp_data
  );

  modport slave (
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata, solu_rdata,
    output disp_req, disp_addr,
    input  disp_gnt, disp_valid, disp_data
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   req_a/b    : requests (a = internal, b = display in board_sched)
//   gnt_a/b    : combinational one-hot grants, same cycle as the request
// A lone requester always wins; on contention the side not granted last wins.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  // prio_b = 1: requester b wins the next contention.
  logic prio_b;

  assign gnt_b = req_b && (!req_a || prio_b);
  assign gnt_a = req_a && !gnt_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_b <= 1'b1;
    end else if (gnt_a) begin
      prio_b <= 1'b1;
    end else if (gnt_b) begin
      prio_b <= 1'b0;
    end
  end

endmodule

// File: rtl/board_sched.sv
// board_sched: cursor/command controller for a 9x9 digit board sharing one
// memory port between its own traffic (user writes, solution check reads)
// and a display reader.
//
// Ports:
//   Clk, Reset              : clock, synchronous active-low reset
//   R, L, U, D, C           : cursor move / write command pulses
//   CheckSolu, Ack          : start check / acknowledge result pulses
//   userIn                  : digit written by C (values above 9 ignored)
//   bus                     : board memory + display port (board_sched_if)
//   row, col                : cursor position
//   q_I .. q_Incorrect      : one-hot controller state
//   init                    : one-cycle board reload pulse after state I
//   err_count               : mismatches found by the last check (sat. at N_CELLS)
module board_sched
  import sindoku_pkg::*;
#(
  parameter int N_CELLS  = N_CELLS_DEF,
  parameter int LAST_IDX = LAST_IDX_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 R,
  input  logic                 L,
  input  logic                 U,
  input  logic                 D,
  input  logic                 C,
  input  logic                 CheckSolu,
  input  logic                 Ack,
  input  logic [DATA_W-1:0]    userIn,
  board_sched_if.master        bus,
  output logic [POS_W-1:0]     row,
  output logic [POS_W-1:0]     col,
  output logic                 q_I,
  output logic                 q_Solve,
  output logic                 q_Check,
  output logic                 q_Correct,
  output logic                 q_Incorrect,
  output logic                 init,
  output logic [ADDR_W-1:0]    err_count
);

  state_t state;

  // One-entry pending write buffer.
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;

  // Check sequencing: chk_idx is the next cell to read; rd_pend marks that
  // mem_rdata/solu_rdata this cycle belong to a check read, rd_last that it
  // was the final cell.
  logic [ADDR_W-1:0] chk_idx;
  logic              rd_pend;
  logic              rd_last;

  logic              disp_valid_q;

  logic              chk_req;
  logic              int_req;
  logic              disp_req_m;
  logic              int_gnt;
  logic              disp_gnt_w;
  logic              chk_issue;
  logic              mismatch;

  // A pending write always goes out before any check read, so a write queued
  // just before CheckSolu lands ahead of the compare of its cell.
  assign chk_req    = (state == S_CHECK) && !pend_valid &&
                      (chk_idx < ADDR_W'(N_CELLS));
  // Requests are masked during reset so no grant or write strobe leaks out.
  assign int_req    = Reset && (pend_valid || chk_req);
  assign disp_req_m = Reset && bus.disp_req;

  rr_arb2 u_arb (
    .clk   (Clk),
    .rst_n (Reset),
    .req_a (int_req),
    .req_b (disp_req_m),
    .gnt_a (int_gnt),
    .gnt_b (disp_gnt_w)
  );

  assign chk_issue = int_gnt && !pend_valid;
  assign mismatch  = rd_pend && (bus.mem_rdata != bus.solu_rdata);

  assign bus.disp_gnt   = disp_gnt_w;
  assign bus.mem_we     = int_gnt && pend_valid;
  assign bus.mem_wdata  = pend_data;
  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_data  = disp_valid_q ? bus.mem_rdata : '0;

  always_comb begin
    bus.mem_addr = '0;
    if (disp_gnt_w) begin
      bus.mem_addr = bus.disp_addr;
    end else if (int_gnt) begin
      bus.mem_addr = pend_valid ? pend_addr : chk_idx;
    end
  end

  assign q_I         = (state == S_I);
  assign q_Solve     = (state == S_SOLVE);
  assign q_Check     = (state == S_CHECK);
  assign q_Correct   = (state == S_CORRECT);
  assign q_Incorrect = (state == S_INCORRECT);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= S_I;
      row          <= '0;
      col          <= '0;
      pend_valid   <= 1'b0;
      pend_addr    <= '0;
      pend_data    <= '0;
      chk_idx      <= '0;
      rd_pend      <= 1'b0;
      rd_last      <= 1'b0;
      err_count    <= '0;
      init         <= 1'b0;
      disp_valid_q <= 1'b0;
    end else begin
      init         <= 1'b0;
      disp_valid_q <= disp_gnt_w;
      rd_pend      <= chk_issue;
      rd_last      <= chk_issue && (chk_idx == ADDR_W'(N_CELLS - 1));

      if (bus.mem_we) begin
        pend_valid <= 1'b0;
      end
      if (chk_issue) begin
        chk_idx <= chk_idx + 1'b1;
      end

      case (state)
        S_I: begin
          init  <= 1'b1;
          row   <= '0;
          col   <= '0;
          state <= S_SOLVE;
        end

        S_SOLVE: begin
          // Fixed priority; anything below the winner is dropped.
          if (CheckSolu) begin
            err_count <= '0;
            chk_idx   <= '0;
            state     <= S_CHECK;
          end else if (R) begin
            if (col < POS_W'(LAST_IDX)) col <= col + 1'b1;
          end else if (L) begin
            if (col != '0) col <= col - 1'b1;
          end else if (U) begin
            if (row != '0) row <= row - 1'b1;
          end else if (D) begin
            if (row < POS_W'(LAST_IDX)) row <= row + 1'b1;
          end else if (C) begin
            // A full buffer drops the new write rather than overwriting.
            if ((userIn <= DATA_W'(9)) && !pend_valid) begin
              pend_valid <= 1'b1;
              pend_addr  <= cell_addr(row, col, LAST_IDX + 1);
              pend_data  <= userIn;
            end
          end
        end

        S_CHECK: begin
          if (mismatch && (err_count < ADDR_W'(N_CELLS))) begin
            err_count <= err_count + 1'b1;
          end
          // The last compare is folded in directly since err_count only
          // reflects it next cycle.
          if (rd_last) begin
            state <= ((err_count == '0) && !mismatch) ? S_CORRECT : S_INCORRECT;
          end
        end

        S_CORRECT, S_INCORRECT: begin
          if (Ack) state <= S_I;
        end

        default: state <= S_I;
      endcase
    end
  end

endmodule

// File: tb/tb_board_sched.sv
module tb_board_sched;
  import sindoku_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              r, l, u, d, c, check_solu, ack;
  logic [DATA_W-1:0] user_in;
  logic [POS_W-1:0]  row, col;
  logic              q_i, q_solve, q_check, q_correct, q_incorrect;
  logic              init;
  logic [ADDR_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  board_sched_if bus ();

  board_sched #(.N_CELLS(81), .LAST_IDX(8)) dut (
    .Clk         (clk),
    .Reset       (rst_n),
    .R           (r),
    .L           (l),
    .U           (u),
    .D           (d),
    .C           (c),
    .CheckSolu   (check_solu),
    .Ack         (ack),
    .userIn      (user_in),
    .bus         (bus),
    .row         (row),
    .col         (col),
    .q_I         (q_i),
    .q_Solve     (q_solve),
    .q_Check     (q_check),
    .q_Correct   (q_correct),
    .q_Incorrect (q_incorrect),
    .init        (init),
    .err_count   (err_count)
  );

  // ---------------- board / solution memory model ----------------
  logic [DATA_W-1:0] board [0:80];
  logic [DATA_W-1:0] solu  [0:80];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 81; i++) board[i] <= DATA_W'(i % 10);
    end else if (bus.mem_we && (bus.mem_addr < 7'd81)) begin
      board[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata  <= (bus.mem_addr < 7'd81) ? board[bus.mem_addr] : '0;
    bus.solu_rdata <= (bus.mem_addr < 7'd81) ? solu[bus.mem_addr]  : '0;
  end

  // ---------------- driver tasks ----------------
  localparam int P_R = 0, P_L = 1, P_U = 2, P_D = 3, P_C = 4, P_CHK = 5, P_ACK = 6;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int which);
    case (which)
      P_R:     r = 1'b1;
      P_L:     l = 1'b1;
      P_U:     u = 1'b1;
      P_D:     d = 1'b1;
      P_C:     c = 1'b1;
      P_CHK:   check_solu = 1'b1;
      default: ack = 1'b1;
    endcase
    tick();
    r = 0; l = 0; u = 0; d = 0; c = 0; check_solu = 0; ack = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0; r = 0; l = 0; u = 0; d = 0; c = 0; check_solu = 0; ack = 0;
    user_in = 0; bus.disp_req = 0; bus.disp_addr = 0;
    for (int i = 0; i < 81; i++) solu[i] = DATA_W'(i % 10);
    repeat (3) tick();
    checks++; if (q_i !== 1'b1) begin errors++; $display("FAIL reset_q_i got %0b exp 1", q_i); end
    checks++; if (q_solve !== 1'b0) begin errors++; $display("FAIL reset_q_solve got %0b exp 0", q_solve); end
    checks++; if (init !== 1'b0) begin errors++; $display("FAIL reset_init got %0b exp 0", init); end
    checks++; if ({row, col} !== 8'h00) begin errors++; $display("FAIL reset_pos got %0d,%0d exp 0,0", row, col); end
    checks++; if (err_count !== 7'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", err_count); end
    checks++; if ({bus.mem_we, bus.disp_gnt, bus.disp_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got %b exp 000", {bus.mem_we, bus.disp_gnt, bus.disp_valid});
    end
  endtask

  task automatic test_idle();
    int n_init;
    rst_n = 1;
    tick();
    checks++; if ({q_solve, init} !== 2'b11) begin errors++; $display("FAIL idle_solve_init got %b exp 11", {q_solve, init}); end
    checks++; if ((q_i + q_solve + q_check + q_correct + q_incorrect) !== 1) begin
      errors++; $display("FAIL idle_onehot got %b exp one bit", {q_i, q_solve, q_check, q_correct, q_incorrect});
    end
    n_init = 0;
    repeat (10) begin tick(); n_init += init; end
    checks++; if (n_init !== 0) begin errors++; $display("FAIL idle_init_once got %0d extra exp 0", n_init); end
    checks++; if ({q_solve, row, col} !== 9'h100) begin errors++; $display("FAIL idle_pos got q=%0b %0d,%0d exp 1 0,0", q_solve, row, col); end
  endtask

  task automatic test_edges();
    pulse(P_L);
    checks++; if (col !== 4'd0) begin errors++; $display("FAIL edge_left got %0d exp 0", col); end
    pulse(P_U);
    checks++; if (row !== 4'd0) begin errors++; $display("FAIL edge_up got %0d exp 0", row); end
    repeat (8) pulse(P_R);
    checks++; if (col !== 4'd8) begin errors++; $display("FAIL move_right got %0d exp 8", col); end
    pulse(P_R);
    checks++; if (col !== 4'd8) begin errors++; $display("FAIL edge_right got %0d exp 8", col); end
    repeat (6) pulse(P_L);
    pulse(P_D);
    checks++; if ({row, col} !== {4'd1, 4'd2}) begin errors++; $display("FAIL move_to_1_2 got %0d,%0d exp 1,2", row, col); end
  endtask

  task automatic test_write();
    int we_n, gnt_n;
    logic [ADDR_W-1:0] we_addr;
    logic [DATA_W-1:0] we_data;
    logic prev_gnt, valid_ok;
    bus.disp_req = 1; bus.disp_addr = 7'd0; user_in = 5'd7;
    pulse(P_C);
    we_n = 0; gnt_n = 0; we_addr = '0; we_data = '0; prev_gnt = 0; valid_ok = 1;
    for (int k = 0; k < 2; k++) begin
      if (bus.mem_we) begin we_n++; we_addr = bus.mem_addr; we_data = bus.mem_wdata; end
      if (bus.disp_gnt) gnt_n++;
      if (k == 1 && bus.disp_valid !== prev_gnt) valid_ok = 0;
      prev_gnt = bus.disp_gnt;
      tick();
    end
    checks++; if (we_n !== 1) begin errors++; $display("FAIL write_we_count got %0d exp 1", we_n); end
    checks++; if (gnt_n !== 1) begin errors++; $display("FAIL write_disp_alt got %0d exp 1", gnt_n); end
    checks++; if ({we_addr, we_data} !== {7'd11, 5'd7}) begin errors++; $display("FAIL write_addr_data got %0d/%0d exp 11/7", we_addr, we_data); end
    checks++; if (valid_ok !== 1'b1) begin errors++; $display("FAIL write_valid_lag got %0b exp 1", valid_ok); end
    bus.disp_addr = 7'd11;
    #1;
    checks++; if (bus.disp_gnt !== 1'b1) begin errors++; $display("FAIL disp_lone_gnt got %0b exp 1", bus.disp_gnt); end
    tick();
    checks++; if ({bus.disp_valid, bus.disp_data} !== {1'b1, 5'd7}) begin
      errors++; $display("FAIL disp_read got %0b/%0d exp 1/7", bus.disp_valid, bus.disp_data);
    end
    bus.disp_req = 0;
  endtask

  task automatic test_bad_write();
    int we_n;
    user_in = 5'd12;
    pulse(P_C);
    we_n = 0;
    repeat (6) begin we_n += bus.mem_we; tick(); end
    checks++; if (we_n !== 0) begin errors++; $display("FAIL bad_digit_we got %0d exp 0", we_n); end
  endtask

  task automatic test_priority();
    int we_n;
    r = 1; l = 1; tick(); r = 0; l = 0;
    checks++; if ({row, col} !== {4'd1, 4'd3}) begin errors++; $display("FAIL prio_r_over_l got %0d,%0d exp 1,3", row, col); end
    user_in = 5'd4; d = 1; c = 1; tick(); d = 0; c = 0;
    we_n = 0;
    repeat (4) begin we_n += bus.mem_we; tick(); end
    checks++; if ({row, col} !== {4'd2, 4'd3}) begin errors++; $display("FAIL prio_d_over_c got %0d,%0d exp 2,3", row, col); end
    checks++; if (we_n !== 0) begin errors++; $display("FAIL prio_c_dropped got %0d exp 0", we_n); end
  endtask

  task automatic test_check_err();
    int n, bad_order;
    solu[11] = 5'd7; solu[40] = 5'd3;
    bus.disp_req = 0;
    pulse(P_CHK);
    n = 0; bad_order = 0;
    while (q_check && n < 400) begin
      if (n < 81 && (bus.mem_addr !== 7'(n) || bus.disp_gnt)) bad_order++;
      n++;
      tick();
    end
    checks++; if (n !== 82) begin errors++; $display("FAIL check_err_cycles got %0d exp 82", n); end
    checks++; if (bad_order !== 0) begin errors++; $display("FAIL check_read_order got %0d bad exp 0", bad_order); end
    checks++; if (err_count !== 7'd1) begin errors++; $display("FAIL check_err_count got %0d exp 1", err_count); end
    checks++; if ({q_incorrect, q_correct} !== 2'b10) begin errors++; $display("FAIL check_incorrect got %b exp 10", {q_incorrect, q_correct}); end
    pulse(P_R);
    checks++; if ({q_incorrect, col} !== {1'b1, 4'd3}) begin errors++; $display("FAIL cmd_ignored got q=%0b col=%0d exp 1/3", q_incorrect, col); end
    pulse(P_ACK);
    checks++; if ({q_i, err_count} !== {1'b1, 7'd1}) begin errors++; $display("FAIL ack_to_i got q=%0b err=%0d exp 1/1", q_i, err_count); end
    tick();
    checks++; if ({q_solve, init, row, col} !== 10'b11_0000_0000) begin
      errors++; $display("FAIL ack_to_solve got q=%0b init=%0b %0d,%0d exp 1 1 0,0", q_solve, init, row, col);
    end
  endtask

  task automatic test_check_ok();
    int n, dg;
    solu[40] = 5'd0;
    bus.disp_req = 1; bus.disp_addr = 7'd5;
    pulse(P_CHK);
    checks++; if ({q_check, err_count} !== {1'b1, 7'd0}) begin errors++; $display("FAIL check_clear got q=%0b err=%0d exp 1/0", q_check, err_count); end
    n = 0; dg = 0;
    while (q_check && n < 400) begin
      dg += bus.disp_gnt;
      n++;
      tick();
    end
    checks++; if (n < 162 || n > 163) begin errors++; $display("FAIL check_ok_cycles got %0d exp 162..163", n); end
    checks++; if (dg !== n - 81) begin errors++; $display("FAIL check_ok_disp_share got %0d exp %0d", dg, n - 81); end
    checks++; if ({q_correct, err_count} !== {1'b1, 7'd0}) begin errors++; $display("FAIL check_correct got q=%0b err=%0d exp 1/0", q_correct, err_count); end
    bus.disp_req = 0;
    pulse(P_ACK);
    tick();
  endtask

  task automatic test_reset_mid_check();
    int bad;
    pulse(P_CHK);
    repeat (20) tick();
    checks++; if (q_check !== 1'b1) begin errors++; $display("FAIL mid_in_check got %0b exp 1", q_check); end
    rst_n = 0;
    tick();
    checks++; if ({q_i, bus.mem_we, err_count} !== {1'b1, 1'b0, 7'd0}) begin
      errors++; $display("FAIL mid_reset got q=%0b we=%0b err=%0d exp 1/0/0", q_i, bus.mem_we, err_count);
    end
    rst_n = 1;
    bad = 0;
    repeat (30) begin
      if (q_check || bus.mem_we) bad++;
      tick();
    end
    checks++; if ({bad, q_solve} !== {32'd0, 1'b1}) begin errors++; $display("FAIL mid_no_reads got bad=%0d q=%0b exp 0/1", bad, q_solve); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_idle();
    test_edges();
    test_write();
    test_bad_write();
    test_priority();
    test_check_err();
    test_check_ok();
    test_reset_mid_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
